instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Writer side of the instruction memory: receives a byte stream from a host link (UART/JTAG bridge) over a valid/ready handshake and assembles little-endian 32-bit instructions. Each complete instruction is written into the instruction memory at consecutive word indices, starting at 0, through a single-cycle write port. The loader holds the core (Cpu_hold) while loading and releases it once the image is complete. It sits between the host link and the instruction memory's write port.

Parameters:
DEPTH, 30, number of 32-bit words in instruction memory; valid word indices 0..DEPTH-1
ADDR_W, 5, width of Wr_addr; must satisfy 2^ADDR_W >= DEPTH

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
Start  input  1  one-cycle pulse; begins a load session
Byte_in  input  8  stream byte from host
Byte_valid  input  1  Byte_in is valid this cycle
Byte_ready  output  1  loader accepts a byte; transfer happens when Byte_valid && Byte_ready
Wr_en  output  1  instruction-memory write strobe, one cycle per word
Wr_addr  output  ADDR_W  word index (same indexing as PC into the memory)
Wr_data  output  32  assembled instruction
Cpu_hold  output  1  core must stall/hold PC while high
Done  output  1  load finished successfully; level, held until next Start
Err  output  1  load failed; level, held until next Start

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE; Byte_ready=0, Wr_en=0, Wr_addr=0, Wr_data=0, Cpu_hold=0, Done=0, Err=0. Cpu_hold=0 lets a preloaded image run without a load.
- States: IDLE, LEN, DATA, WRITE, CHK (optional feature only), DONE, ERR.
- IDLE/DONE/ERR: Byte_ready=0.
  - A Start pulse clears Done, Err, the word counter and the byte counter.
  - The same Start pulse sets Cpu_hold=1 and moves the FSM to LEN.
  - Start in LEN, DATA, WRITE or CHK is ignored.
- LEN: Byte_ready=1. The first accepted byte is the word count N.
  - N==0 or N>DEPTH: go to ERR. No writes occur.
  - Otherwise: latch N and go to DATA.
- DATA: Byte_ready=1.
  - Accepted bytes shift into the word in little-endian order: byte k (0..3) goes to bits [8k+7:8k].
  - On acceptance of the 4th byte, go to WRITE.
- WRITE: lasts exactly 1 cycle. Byte_ready=0. Wr_en=1, Wr_addr=word counter, Wr_data=assembled word.
  - Write latency is 1 cycle after the 4th byte handshake.
  - After the write, the word counter increments.
  - If word counter+1==N, go to DONE (or CHK when the optional feature is enabled).
  - Otherwise return to DATA with the byte counter at 0.
- Wr_en=0 in every state except WRITE. Wr_addr/Wr_data hold their last values outside WRITE.
- DONE: Done=1, Cpu_hold=0. Cpu_hold falls in the same cycle Done rises.
- ERR: Err=1, Cpu_hold stays 1 (core stays frozen on a partial image) until a new Start or reset.
- Byte_valid low stalls the FSM indefinitely; there is no timeout. A byte presented during WRITE is not consumed and stays pending (host must hold it).
- The word counter never exceeds N-1, so Wr_addr never exceeds DEPTH-1. There is no wrap-around.
- rst_n asserted mid-load: immediate return to reset values, including Cpu_hold=0. Words already written remain in memory; the loader does not clear them.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined:
  - After the N-th word write, the FSM enters CHK with Byte_ready=1.
  - The accepted byte is compared with the XOR of all 4N data bytes. The length byte is excluded.
  - Match: go to DONE. Mismatch: go to ERR.
  - The running XOR is cleared on Start.
- Undefined: no CHK state; the FSM goes from the last WRITE directly to DONE, and no trailing byte is consumed.

Test Plan:
- Reset mid-reset check: drive rst_n=0 asynchronously between clock edges -> all outputs 0 immediately, before the next edge.
- Start, then stream 02, 13 00 00 00, B3 00 50 00, valid held high -> Wr_en pulses twice: addr 0 data 0x00000013, addr 1 data 0x005000B3. Done=1 and Cpu_hold=0 on the cycle after the second write.
- Start, length byte 00 -> Err=1, Cpu_hold=1, Wr_en never asserted. Start then length 1F (31 > DEPTH) -> Err=1.
- Gapped Byte_valid (random 0-5 idle cycles between bytes), N=30 -> 30 writes to addrs 0..29 with correct data. Byte_ready=0 in every WRITE cycle. No byte lost or duplicated.
- Start pulsed during DATA -> ignored; load completes normally. Reset after 2 of 3 words -> outputs return to reset values. A new Start then reloads from addr 0.
- LOADER_CHECKSUM_EN defined, N=1, data 13 00 00 00, checksum 13 -> Done=1. Same load with checksum 12 -> Err=1, Cpu_hold=1.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles a little-endian byte stream from the host link
// into 32-bit instructions and writes them to the instruction memory from
// word 0 upward, holding the core while a load is in progress.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module instr_mem_loader #(
  parameter int unsigned DEPTH  = 30,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic [7:0]        Byte_in,
  input  logic              Byte_valid,
  output logic              Byte_ready,
  output logic              Wr_en,
  output logic [ADDR_W-1:0] Wr_addr,
  output logic [31:0]       Wr_data,
  output logic              Cpu_hold,
  output logic              Done,
  output logic              Err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif
  logic              byte_ready_q, byte_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept_c;

  assign accept_c = Byte_valid && byte_ready_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          state_d    = S_LEN;
          word_cnt_d = '0;
          byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
          chk_d      = '0;
`endif
        end
      end
      S_LEN: begin
        if (accept_c) begin
          if (Byte_in == 8'd0 || Byte_in > 8'(DEPTH)) begin
            state_d = S_ERR;
          end else begin
            len_d   = Byte_in;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept_c) begin
          // Shift in from the top so byte 0 ends up in bits [7:0].
          word_d     = {Byte_in, word_q[31:8]};
          byte_cnt_d = 2'(byte_cnt_q + 2'd1);
`ifdef LOADER_CHECKSUM_EN
          chk_d      = chk_q ^ Byte_in;
`endif
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Counter stops at N-1 so it never points past the image.
        if ((8'(word_cnt_q) + 8'd1) == len_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          word_cnt_d = ADDR_W'(word_cnt_q + 1'b1);
          byte_cnt_d = '0;
          state_d    = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept_c) state_d = (Byte_in == chk_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs registered from the next state so they line up with it.
    byte_ready_d = (state_d == S_LEN) || (state_d == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                   || (state_d == S_CHK)
`endif
                   ;
    wr_en_d    = (state_d == S_WRITE);
    wr_addr_d  = wr_en_d ? word_cnt_q : wr_addr_q;
    wr_data_d  = wr_en_d ? word_d : wr_data_q;
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    cpu_hold_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= '0;
`endif
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign Byte_ready = byte_ready_q;
  assign Wr_en      = wr_en_q;
  assign Wr_addr    = wr_addr_q;
  assign Wr_data    = wr_data_q;
  assign Cpu_hold   = cpu_hold_q;
  assign Done       = done_q;
  assign Err        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader; honours LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;

  localparam int unsigned DEPTH  = 30;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              Start = 1'b0;
  logic [7:0]        Byte_in = 8'd0;
  logic              Byte_valid = 1'b0;
  logic              Byte_ready;
  logic              Wr_en;
  logic [ADDR_W-1:0] Wr_addr;
  logic [31:0]       Wr_data;
  logic              Cpu_hold;
  logic              Done;
  logic              Err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int next_addr = 0;
  logic [7:0]  run_xor = 8'd0;
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_data_q[$];

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Byte_in(Byte_in),
    .Byte_valid(Byte_valid), .Byte_ready(Byte_ready), .Wr_en(Wr_en),
    .Wr_addr(Wr_addr), .Wr_data(Wr_data), .Cpu_hold(Cpu_hold),
    .Done(Done), .Err(Err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe pops the scoreboard.
  always @(negedge clk) begin
    if (rst_n && Wr_en) begin
      n_wr++;
      check("ready_in_write", 32'(Byte_ready), 32'd0);
      if (exp_addr_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        check("wr_addr", 32'(Wr_addr), 32'(exp_addr_q.pop_front()));
        check("wr_data", Wr_data, exp_data_q.pop_front());
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); Start = 1'b1;
    @(negedge clk); Start = 1'b0;
  endtask

  task automatic begin_load();
    pulse_start();
    run_xor   = 8'd0;
    next_addr = 0;
    check("hold_after_start", 32'(Cpu_hold), 32'd1);
    check("ready_in_len", 32'(Byte_ready), 32'd1);
    check("done_cleared", 32'(Done), 32'd0);
    check("err_cleared", 32'(Err), 32'd0);
  endtask

  // Present a byte after 'gap' idle cycles; returns one negedge after the handshake.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      Byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    Byte_valid = 1'b1;
    Byte_in    = b;
    n = 0;
    while (!Byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!Byte_ready) check("handshake_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] data, input int gapmax);
    exp_addr_q.push_back(ADDR_W'(next_addr));
    exp_data_q.push_back(data);
    next_addr++;
    for (int k = 0; k < 4; k++) begin
      run_xor = run_xor ^ data[8*k +: 8];
      send_byte(data[8*k +: 8], int'($urandom_range(0, gapmax)));
    end
  endtask

  task automatic finish_load(input logic bad_chk);
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_chk ? (run_xor ^ 8'h01) : run_xor, 0);
`else
    if (bad_chk) check("bad_chk_needs_feature", 32'd0, 32'd1);
`endif
    Byte_valid = 1'b0;
  endtask

  task automatic wait_end(input logic exp_done);
    int n;
    n = 0;
    while (!(Done || Err) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("end_done", 32'(Done), 32'(exp_done));
    check("end_err", 32'(Err), 32'(!exp_done));
    check("end_hold", 32'(Cpu_hold), 32'(!exp_done));
    check("end_ready", 32'(Byte_ready), 32'd0);
    check("sb_drained", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(Byte_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(Wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(Wr_addr), 32'd0);
    check({tag, "_wr_data"}, Wr_data, 32'd0);
    check({tag, "_hold"}, 32'(Cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(Done), 32'd0);
    check({tag, "_err"}, 32'(Err), 32'd0);
  endtask

  initial begin
    int wr_before;
    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two-word load, valid held high.
    begin_load();
    send_byte(8'h02, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0050_00B3, 0);
`ifndef LOADER_CHECKSUM_EN
    check("last_write_now", 32'(Wr_en), 32'd1);
    check("no_done_in_write", 32'(Done), 32'd0);
    @(negedge clk);
    check("done_after_write", 32'(Done), 32'd1);
    check("hold_released", 32'(Cpu_hold), 32'd0);
`endif
    finish_load(1'b0);
    wait_end(1'b1);

    // Zero length and oversize length.
    wr_before = n_wr;
    begin_load();
    send_byte(8'h00, 0);
    Byte_valid = 1'b0;
    check("len0_err", 32'(Err), 32'd1);
    check("len0_hold", 32'(Cpu_hold), 32'd1);
    begin_load();
    send_byte(8'h1F, 0);
    Byte_valid = 1'b0;
    check("len31_err", 32'(Err), 32'd1);
    check("len31_hold", 32'(Cpu_hold), 32'd1);
    repeat (3) @(negedge clk);
    check("err_no_writes", 32'(n_wr - wr_before), 32'd0);
    check("err_held", 32'(Err), 32'd1);

    // Full-depth load with gapped valid.
    wr_before = n_wr;
    begin_load();
    send_byte(8'(DEPTH), int'($urandom_range(0, 5)));
    for (int i = 0; i < int'(DEPTH); i++) send_word($urandom, 5);
    finish_load(1'b0);
    wait_end(1'b1);
    check("depth_write_count", 32'(n_wr - wr_before), 32'(DEPTH));

    // Start during DATA is ignored.
    begin_load();
    send_byte(8'h02, 0);
    send_word(32'hDEAD_BEEF, 1);
    Byte_valid = 1'b0;
    pulse_start();
    check("start_ignored_hold", 32'(Cpu_hold), 32'd1);
    send_word(32'h1234_5678, 2);
    finish_load(1'b0);
    wait_end(1'b1);

    // Reset after 2 of 3 words, then reload from address 0.
    begin_load();
    send_byte(8'h03, 0);
    send_word(32'hA5A5_0001, 0);
    send_word(32'hA5A5_0002, 0);
    Byte_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_addr", 32'(Wr_addr), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midload_reset");
    @(negedge clk);
    rst_n = 1'b1;
    begin_load();
    send_byte(8'h03, 0);
    send_word(32'h0000_0111, 0);
    send_word(32'h0000_0222, 3);
    send_word(32'h0000_0333, 0);
    finish_load(1'b0);
    wait_end(1'b1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch on a one-word image.
    begin_load();
    send_byte(8'h01, 0);
    send_word(32'h0000_0013, 0);
    check("chk_value", 32'(run_xor), 32'h13);
    finish_load(1'b0);
    wait_end(1'b1);
    begin_load();
    send_byte(8'h01, 0);
    send_word(32'h0000_0013, 0);
    finish_load(1'b1);
    wait_end(1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
